// File: rtl/shift_add_multiplier_4.sv
// Sequential unsigned W x W shift-and-add multiplier.
// One W-bit ripple-carry adder (a chain of 4-bit ripple-carry slices) is
// reused every cycle; one product is delivered every W+2 cycles.

// Single-bit full adder used as the leaf of every ripple-carry slice.
module sam_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// 4-bit ripple-carry adder slice; the multiplier chains W/4 of these.
module sam_rca_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;
  assign co   = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_bit
    sam_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

endmodule

// Top: control FSM, operand registers and the shared adder chain.
module shift_add_multiplier_4 #(
  parameter int W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_p
);

  localparam int NSLICE = W / 4;
  localparam int CW     = $clog2(W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  m;
  logic [W-1:0]  q;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  logic [W-1:0]      add_b;
  logic [W-1:0]      sum;
  logic [NSLICE:0]   carry;

  // Second adder operand: the multiplicand when the current multiplier bit is set.
  always_comb begin
    add_b = q[0] ? m : '0;
  end

  assign carry[0] = 1'b0;

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    sam_rca_4 u_rca (
      .a  (acc[4*g +: 4]),
      .b  (add_b[4*g +: 4]),
      .ci (carry[g]),
      .s  (sum[4*g +: 4]),
      .co (carry[g+1])
    );
  end

  // FSM and datapath registers; the adder carry-out becomes the new acc MSB.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      m     <= '0;
      q     <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            m     <= i_a;
            q     <= i_b;
            acc   <= '0;
            cnt   <= CW'(W);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= {carry[NSLICE], sum[W-1:1]};
          q   <= {sum[0], q[W-1:1]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags are pure decodes of the registered state.
  always_comb begin
    o_busy = (state == ST_RUN);
    o_done = (state == ST_DONE);
    o_p    = {acc, q};
  end

endmodule

// File: tb/tb_shift_add_multiplier_4.sv
// Scoreboard bench for shift_add_multiplier_4 (W=4): the stimulus pushes the
// expected product when it issues a start, the monitor pops on every o_done.
module tb_shift_add_multiplier_4;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  logic [2*W-1:0] exp_q[$];

  shift_add_multiplier_4 #(.W(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: on every done cycle pop one expected product and compare.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      check("busy_low_in_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got p=%0h expected no done", p);
      end else begin
        check("product", {24'd0, p}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiplication from IDLE and follow it through RUN and DONE.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [2*W-1:0] exp_p, input bit full_check);
    int n_busy;
    exp_q.push_back(exp_p);
    a = xa;
    b = xb;
    start = 1'b1;
    step();
    start = 1'b0;
    n_busy = 0;
    while (busy && n_busy < 20) begin
      n_busy++;
      step();
    end
    if (full_check) begin
      check("busy_cycles", n_busy, W);
      check("done_after_run", {31'd0, done}, 32'd1);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1");
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    step();
    if (full_check) begin
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("hold_in_idle", {24'd0, p}, {24'd0, exp_p});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_p", {24'd0, p}, 32'd0);
    rst_n = 1'b1;
    step();

    // 15*15, then hold.
    do_op(4'hF, 4'hF, 8'hE1, 1'b1);
    step();
    check("hold_e1", {24'd0, p}, 32'hE1);

    // Back to back: second start on the first IDLE cycle after done.
    do_op(4'h6, 4'h7, 8'h2A, 1'b1);
    do_op(4'h0, 4'h9, 8'h00, 1'b1);

    // Exhaustive sweep (includes 1*x and x*1).
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_op(4'(i), 4'(j), 8'(i * j), 1'b0);
      end
    end

    // i_start held high with toggling operands: accepts every W+2 cycles.
    begin
      int base_done;
      base_done = n_done;
      for (int k = 0; k < 3 * (W + 2); k++) begin
        a = 4'(k + 3);
        b = 4'(5 * k + 1);
        start = 1'b1;
        if (k % (W + 2) == 0) exp_q.push_back(8'((k + 3) % 16) * 8'((5 * k + 1) % 16));
        step();
      end
      start = 1'b0;
      a = 4'hA;
      b = 4'h5;
      for (int k = 0; k < 8; k++) step();
      check("held_start_products", n_done - base_done, 3);
      check("held_start_queue", exp_q.size(), 0);
    end

    // Reset in the 2nd RUN cycle of 9*9 aborts it.
    a = 4'h9;
    b = 4'h9;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_p", {24'd0, p}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    do_op(4'h3, 4'h5, 8'h0F, 1'b1);

    // Reset together with start in IDLE.
    rst_n = 1'b0;
    start = 1'b1;
    a = 4'hC;
    b = 4'hD;
    step();
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    check("rst_start_p", {24'd0, p}, 32'd0);
    start = 1'b0;
    step();
    check("rst_start_done", {31'd0, done}, 32'd0);
    check("rst_start_idle", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
